// File: rtl/cronometro_pkg.sv
// Shared encodings for the stopwatch controller: FSM states and button indices.
package cronometro_pkg;

  localparam int ESTADO_W = 3;

  typedef enum logic [ESTADO_W-1:0] {
    INICIO = 3'd0,
    CONTAR = 3'd1,
    PAUSAR = 3'd2,
    PARAR  = 3'd3,
    VOLTA  = 3'd4
  } estado_e;

  localparam int BTN_CONTA = 0;
  localparam int BTN_PAUSA = 1;
  localparam int BTN_PARA  = 2;
  localparam int BTN_VOLTA = 3;
  localparam int N_BTN     = 4;

endpackage

// File: rtl/botao_cond.sv
// Active-low push-button conditioner: 2-flop synchroniser, optional debounce
// (CRONOMETRO_DEBOUNCE_EN), falling-edge detect into a registered 1-cycle pulse.
module botao_cond #(
  parameter int DEB_CICLOS = 250000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_ni,
  output logic pulso_o
);

  logic s1_q, s2_q, nivel, nivel_ant_q, pulso_q;

  // Idle level is high, so flops reset to 1 to avoid a pulse on reset release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= btn_ni;
      s2_q <= s1_q;
    end
  end

`ifdef CRONOMETRO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEB_CICLOS + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             estavel_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      estavel_q <= 1'b1;
    end else if (s2_q == estavel_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_W'(DEB_CICLOS - 1)) begin
      estavel_q <= s2_q;
      cnt_q     <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign nivel = estavel_q;
`else
  assign nivel = s2_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      nivel_ant_q <= 1'b1;
      pulso_q     <= 1'b0;
    end else begin
      nivel_ant_q <= nivel;
      pulso_q     <= nivel_ant_q & ~nivel;
    end
  end

  assign pulso_o = pulso_q;

endmodule

// File: rtl/cronometro_ctrl.sv
// Stopwatch controller: button conditioning, run/pause/stop/lap FSM, prescaled
// saturating time counter and lap memory. Debounce enabled by CRONOMETRO_DEBOUNCE_EN.
module cronometro_ctrl
  import cronometro_pkg::*;
#(
  parameter int TICK_DIV   = 500000,
  parameter int TEMPO_W    = 24,
  parameter int N_VOLTAS   = 4,
  parameter int DEB_CICLOS = 250000,
  localparam int SEL_W     = (N_VOLTAS > 1) ? $clog2(N_VOLTAS) : 1,
  localparam int QTD_W     = $clog2(N_VOLTAS + 1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               conta_i,
  input  logic               pausa_i,
  input  logic               para_i,
  input  logic               volta_i,
  input  logic [SEL_W-1:0]   volta_sel_i,
  output logic [ESTADO_W-1:0] estado_o,
  output logic               contando_o,
  output logic [TEMPO_W-1:0] tempo_o,
  output logic [TEMPO_W-1:0] tempo_exibido_o,
  output logic [TEMPO_W-1:0] volta_dado_o,
  output logic [QTD_W-1:0]   volta_qtd_o,
  output logic               volta_cheia_o,
  output logic               estouro_o
);

  localparam int PS_W = $clog2(TICK_DIV);

  logic [N_BTN-1:0] btn_n, pulso;

  assign btn_n[BTN_CONTA] = conta_i;
  assign btn_n[BTN_PAUSA] = pausa_i;
  assign btn_n[BTN_PARA]  = para_i;
  assign btn_n[BTN_VOLTA] = volta_i;

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    botao_cond #(.DEB_CICLOS(DEB_CICLOS)) u_btn (
      .clk_i   (clk_i),
      .rst_ni  (reset_i),
      .btn_ni  (btn_n[g]),
      .pulso_o (pulso[g])
    );
  end

  estado_e            estado_q, estado_d;
  logic               contando_q;
  logic [PS_W-1:0]    presc_q;
  logic [TEMPO_W-1:0] tempo_q;
  logic               estouro_q;
  logic [QTD_W-1:0]   qtd_q;
  logic [TEMPO_W-1:0] voltas_q [N_VOLTAS];

  // Only the highest-priority pulse of a cycle is seen by the FSM.
  logic cmd_para, cmd_pausa, cmd_conta, cmd_volta;
  assign cmd_para  = pulso[BTN_PARA];
  assign cmd_pausa = pulso[BTN_PAUSA] & ~cmd_para;
  assign cmd_conta = pulso[BTN_CONTA] & ~pulso[BTN_PARA] & ~pulso[BTN_PAUSA];
  assign cmd_volta = pulso[BTN_VOLTA] & ~pulso[BTN_PARA] & ~pulso[BTN_PAUSA]
                   & ~pulso[BTN_CONTA];

  logic cheia, gravar, limpar, wrap;
  assign cheia  = (qtd_q == QTD_W'(N_VOLTAS));
  assign gravar = cmd_volta & ~cheia & contando_q;
  assign limpar = cmd_conta & (estado_q == PARAR);
  assign wrap   = (presc_q == PS_W'(TICK_DIV - 1));

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      INICIO: if (cmd_conta) estado_d = CONTAR;
      CONTAR, VOLTA: begin
        if (cmd_para)                            estado_d = PARAR;
        else if (cmd_pausa)                      estado_d = PAUSAR;
        else if (cmd_conta)                      estado_d = CONTAR;
        else if (gravar)                         estado_d = VOLTA;
      end
      PAUSAR: begin
        if (cmd_para)       estado_d = PARAR;
        else if (cmd_conta) estado_d = CONTAR;
      end
      PARAR:   if (cmd_conta) estado_d = CONTAR;
      default: estado_d = INICIO;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      estado_q   <= INICIO;
      contando_q <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      contando_q <= (estado_d == CONTAR) || (estado_d == VOLTA);
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      presc_q   <= '0;
      tempo_q   <= '0;
      estouro_q <= 1'b0;
      qtd_q     <= '0;
      for (int i = 0; i < N_VOLTAS; i++) voltas_q[i] <= '0;
    end else if (limpar) begin
      presc_q   <= '0;
      tempo_q   <= '0;
      estouro_q <= 1'b0;
      qtd_q     <= '0;
      for (int i = 0; i < N_VOLTAS; i++) voltas_q[i] <= '0;
    end else begin
      // Lap captures the value before this cycle's increment.
      if (gravar) begin
        for (int i = 0; i < N_VOLTAS; i++)
          if (qtd_q == QTD_W'(i)) voltas_q[i] <= tempo_q;
        qtd_q <= qtd_q + 1'b1;
      end
      if (contando_q) begin
        if (wrap) begin
          presc_q <= '0;
          if (&tempo_q) estouro_q <= 1'b1;
          else          tempo_q   <= tempo_q + 1'b1;
        end else begin
          presc_q <= presc_q + 1'b1;
        end
      end
    end
  end

  logic [TEMPO_W-1:0] ultima, dado;
  always_comb begin
    ultima = '0;
    dado   = '0;
    for (int i = 0; i < N_VOLTAS; i++) begin
      if (qtd_q == QTD_W'(i + 1)) ultima = voltas_q[i];
      if ((volta_sel_i == SEL_W'(i)) && (QTD_W'(i) < qtd_q)) dado = voltas_q[i];
    end
  end

  assign estado_o        = estado_q;
  assign contando_o      = contando_q;
  assign tempo_o         = tempo_q;
  assign tempo_exibido_o = (estado_q == VOLTA) ? ultima : tempo_q;
  assign volta_dado_o    = dado;
  assign volta_qtd_o     = qtd_q;
  assign volta_cheia_o   = cheia;
  assign estouro_o       = estouro_q;

endmodule

// File: tb/tb_cronometro_ctrl.sv
// Bench for cronometro_ctrl: a wide and a 4-bit-time instance share stimulus and
// are checked every cycle against a unit-counting behavioural model.
module tb_cronometro_ctrl;

  localparam int TD = 4;
  localparam int NV = 2;
  localparam int DEB = 3;
`ifdef CRONOMETRO_DEBOUNCE_EN
  localparam int DEB_LAT = DEB;
  localparam int MINHOLD = DEB;
`else
  localparam int DEB_LAT = 0;
  localparam int MINHOLD = 1;
`endif
  // Pin driven low just after edge k -> state change at edge k+4 (+debounce).
  localparam int LAT  = 4 + DEB_LAT;
  localparam int MAXC = 8192;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic conta = 1'b1, pausa = 1'b1, para = 1'b1, volta = 1'b1;
  logic sel = 1'b0;

  logic [2:0]  a_est, b_est;
  logic        a_cnt, b_cnt, a_cheia, b_cheia, a_est_ov, b_est_ov;
  logic [23:0] a_tempo, a_exib, a_dado;
  logic [3:0]  b_tempo, b_exib, b_dado;
  logic [1:0]  a_qtd, b_qtd;

  always #5 clk = ~clk;

  cronometro_ctrl #(.TICK_DIV(TD), .TEMPO_W(24), .N_VOLTAS(NV), .DEB_CICLOS(DEB)) u_dut (
    .clk_i(clk), .reset_i(rst_n), .conta_i(conta), .pausa_i(pausa), .para_i(para),
    .volta_i(volta), .volta_sel_i(sel), .estado_o(a_est), .contando_o(a_cnt),
    .tempo_o(a_tempo), .tempo_exibido_o(a_exib), .volta_dado_o(a_dado),
    .volta_qtd_o(a_qtd), .volta_cheia_o(a_cheia), .estouro_o(a_est_ov));

  cronometro_ctrl #(.TICK_DIV(TD), .TEMPO_W(4), .N_VOLTAS(NV), .DEB_CICLOS(DEB)) u_sat (
    .clk_i(clk), .reset_i(rst_n), .conta_i(conta), .pausa_i(pausa), .para_i(para),
    .volta_i(volta), .volta_sel_i(sel), .estado_o(b_est), .contando_o(b_cnt),
    .tempo_o(b_tempo), .tempo_exibido_o(b_exib), .volta_dado_o(b_dado),
    .volta_qtd_o(b_qtd), .volta_cheia_o(b_cheia), .estouro_o(b_est_ov));

  int checks = 0, errors = 0, cyc = 0;
  logic [3:0] evt [MAXC];  // bit0 conta, bit1 pausa, bit2 para, bit3 volta

  // Model: unbounded count of increment attempts since the last clear;
  // each instance's tempo/estouro follow from clipping to its width.
  int m_state, m_presc, m_units;
  int m_laps[$];

  function automatic int clip(int u, int w);
    int mx = (1 << w) - 1;
    return (u > mx) ? mx : u;
  endfunction

  task automatic model_reset();
    m_state = 0; m_presc = 0; m_units = 0;
    m_laps.delete();
    for (int i = 0; i < MAXC; i++) evt[i] = 4'b0;
  endtask

  task automatic model_step(input logic [3:0] p);
    int top;
    bit running;
    running = (m_state == 1) || (m_state == 4);
    top = p[2] ? 2 : p[1] ? 1 : p[0] ? 0 : p[3] ? 3 : -1;
    case (m_state)
      0: if (top == 0) m_state = 1;
      1, 4: begin
        if (top == 2) m_state = 3;
        else if (top == 1) m_state = 2;
        else if (top == 0) m_state = 1;
        else if (top == 3 && m_laps.size() < NV) begin
          m_laps.push_back(m_units);
          m_state = 4;
        end
      end
      2: if (top == 0) m_state = 1; else if (top == 2) m_state = 3;
      3: if (top == 0) begin
        m_state = 1; m_units = 0; m_presc = 0; m_laps.delete();
      end
      default: ;
    endcase
    if (running) begin
      m_presc++;
      if (m_presc == TD) begin m_presc = 0; m_units++; end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_all();
    int n = m_laps.size();
    int idx = int'(sel);
    int lap = (idx < n) ? m_laps[idx] : 0;
    int cur = (m_state == 4) ? m_laps[n-1] : m_units;
    chk("estado",       32'(a_est),    32'(m_state));
    chk("estado_sat",   32'(b_est),    32'(m_state));
    chk("contando",     32'(a_cnt),    32'((m_state == 1) || (m_state == 4)));
    chk("tempo",        32'(a_tempo),  32'(clip(m_units, 24)));
    chk("tempo_sat",    32'(b_tempo),  32'(clip(m_units, 4)));
    chk("exibido",      32'(a_exib),   32'(clip(cur, 24)));
    chk("exibido_sat",  32'(b_exib),   32'(clip(cur, 4)));
    chk("volta_dado",   32'(a_dado),   32'(clip(lap, 24)));
    chk("volta_dado_s", 32'(b_dado),   32'(clip(lap, 4)));
    chk("volta_qtd",    32'(a_qtd),    32'(n));
    chk("volta_cheia",  32'(a_cheia),  32'(n == NV));
    chk("estouro",      32'(a_est_ov), 32'(m_units > (1 << 24) - 1));
    chk("estouro_sat",  32'(b_est_ov), 32'(m_units > 15));
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (rst_n && cyc < MAXC) model_step(evt[cyc]);
    #1;
    check_all();
    sel = 1'($urandom_range(0, 1));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_pins(input logic [3:0] m, input logic lvl);
    if (m[0]) conta = lvl;
    if (m[1]) pausa = lvl;
    if (m[2]) para  = lvl;
    if (m[3]) volta = lvl;
  endtask

  // Holds the masked pins low for 'hold' cycles; long enough presses produce one event.
  task automatic press(input logic [3:0] m, input int hold);
    if (hold >= MINHOLD && cyc + LAT < MAXC) evt[cyc + LAT] = evt[cyc + LAT] | m;
    set_pins(m, 1'b0);
    run(hold);
    set_pins(m, 1'b1);
  endtask

  initial begin
    model_reset();
    run(3);
    rst_n = 1'b1;
    run(2);

    // Start, then 40 cycles of counting after the transition.
    press(4'b0001, 1);
    run(LAT - 1);
    chk("tp_estado_start", 32'(a_est), 32'd1);
    run(40);
    chk("tp_tempo10", 32'(a_tempo), 32'd10);
    chk("tp_contando", 32'(a_cnt), 32'd1);

    // Pause, hold, resume.
    press(4'b0010, 1);
    run(LAT + 20);
    chk("tp_pausado", 32'(a_est), 32'd2);
    press(4'b0001, 1);
    run(LAT + 8);

    // Three laps with the memory holding two.
    for (int k = 0; k < 3; k++) begin
      press(4'b1000, 1);
      run(LAT + 14);
    end
    chk("tp_qtd2", 32'(a_qtd), 32'd2);
    chk("tp_cheia", 32'(a_cheia), 32'd1);

    // Stop and pause together: stop wins; conta then clears everything.
    press(4'b0110, 1);
    run(LAT + 4);
    chk("tp_parar", 32'(a_est), 32'd3);
    press(4'b0001, 1);
    run(LAT + 2);
    chk("tp_qtd0", 32'(a_qtd), 32'd0);
    chk("tp_ov0", 32'(b_est_ov), 32'd0);

    // Saturate the 4-bit instance.
    run(16 * TD + 12);
    chk("tp_sat15", 32'(b_tempo), 32'd15);
    chk("tp_sat_ov", 32'(b_est_ov), 32'd1);
    chk("tp_sat_cnt", 32'(b_cnt), 32'd1);

    // Asynchronous reset mid-count.
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("tp_rst_tempo", 32'(a_tempo), 32'd0);
    run(2);
    rst_n = 1'b1;
    run(3);

`ifdef CRONOMETRO_DEBOUNCE_EN
    press(4'b0001, 2);
    run(20);
    chk("tp_glitch", 32'(a_est), 32'd0);
    press(4'b0001, 5);
    run(LAT + 2);
    chk("tp_deb_start", 32'(a_est), 32'd1);
`endif

    // Random button activity against the model.
    for (int it = 0; it < 80; it++) begin
      logic [3:0] m;
      int r = $urandom_range(0, 9);
      if (r < 8) m = 4'(1 << (r % 4));
      else       m = 4'($urandom_range(1, 15));
      press(m, $urandom_range(MINHOLD > 1 ? MINHOLD - 1 : 1, MINHOLD + 2));
      run($urandom_range(DEB_LAT + 3, 30));
    end
    run(LAT + 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
